// File: rtl/vdac_capture_if.sv
// Output stream of vdac_capture: recovered 15-bit RGB word plus frame/line flags
// with a valid/ready handshake.
interface vdac_capture_if;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_data;
    logic        out_sof;
    logic        out_sol;

    modport master (
        output out_valid,
        output out_data,
        output out_sof,
        output out_sol,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_sol,
        output out_ready
    );
endinterface

// File: rtl/vdac_capture.sv
// Recovers 5-bit colour codes from 8-bit VDAC-level samples, packs them into
// 15-bit RGB words and buffers them in a small FIFO; also tracks the line count.
module vdac_capture #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LINE_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_sol,
    input  logic [7:0]        v_r,
    input  logic [7:0]        v_g,
    input  logic [7:0]        v_b,
    vdac_capture_if.master    vout,
    output logic [LINE_W-1:0] line_cnt,
    output logic              overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Nearest code for a scaled level: counts thresholds of v*24+127 against 255*k.
    function automatic logic [4:0] scale5(input logic [7:0] v);
        logic [12:0] x;
        logic [4:0]  q;
        x = 13'(v) * 13'd24 + 13'd127;
        q = '0;
        for (int unsigned k = 1; k <= 24; k++) begin
            if (x >= 13'(255 * k))
                q = q + 5'd1;
        end
        return q;
    endfunction

    logic       s1_valid, s1_mode, s1_sof, s1_sol;
    logic [7:0] s1_r, s1_g, s1_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_sof   <= 1'b0;
            s1_sol   <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            line_cnt <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_r    <= v_r;
                s1_g    <= v_g;
                s1_b    <= v_b;
                s1_mode <= mode;
                s1_sof  <= in_sof;
                s1_sol  <= in_sol;
                if (in_sof)
                    line_cnt <= '0;
                else if (in_sol && line_cnt != '1)
                    line_cnt <= line_cnt + LINE_W'(1);
            end
        end
    end

    logic [4:0] c_r, c_g, c_b;

    always_comb begin
        c_r = s1_mode ? s1_r[7:3] : scale5(s1_r);
        c_g = s1_mode ? s1_g[7:3] : scale5(s1_g);
        c_b = s1_mode ? s1_b[7:3] : scale5(s1_b);
    end

    logic        s2_valid, s2_sof, s2_sol;
    logic [14:0] s2_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_sol   <= 1'b0;
            s2_word  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_sol   <= s1_sol;
            s2_word  <= {c_r, c_g, c_b};
        end
    end

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, push, pop;
    logic [16:0]   head;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    always_comb begin
        full = (count == (AW+1)'(FIFO_DEPTH));
        pop  = vout.out_valid & vout.out_ready;
        push = s2_valid & (~full | pop);
        head = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s2_word, s2_sof, s2_sol};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
            if (s2_valid && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        vout.out_valid = (count != '0);
        vout.out_data  = vout.out_valid ? head[16:2] : '0;
        vout.out_sof   = vout.out_valid ? head[1] : 1'b0;
        vout.out_sol   = vout.out_valid ? head[0] : 1'b0;
    end

endmodule

// File: tb/tb_vdac_capture.sv
// Randomised and directed bench for vdac_capture against a queue-based model
// of the two-stage pipeline and output FIFO.
module tb_vdac_capture;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 10;

    logic          clk = 1'b0;
    logic          rst, mode, in_valid, in_sof, in_sol;
    logic [7:0]    v_r, v_g, v_b;
    logic [LW-1:0] line_cnt;
    logic          overflow;

    vdac_capture_if vif ();

    vdac_capture #(.FIFO_DEPTH(DEPTH), .LINE_W(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_sol   (in_sol),
        .v_r      (v_r),
        .v_g      (v_g),
        .v_b      (v_b),
        .vout     (vif),
        .line_cnt (line_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [14:0] w;
        bit        sof;
        bit        sol;
    } ent_t;

    ent_t        dl0, dl1;
    ent_t        fq[$];
    bit          m_ovf;
    int unsigned m_lc;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [4:0] ref_code(input bit md, input int unsigned v);
        int unsigned q;
        if (md)
            q = v / 8;
        else begin
            q = (v * 24 + 127) / 255;
            if (q > 24) q = 24;
        end
        return 5'(q);
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare at negedge.
    task automatic step(input bit r_, input bit iv, input bit isof, input bit isol,
                        input bit md, input bit [7:0] r, input bit [7:0] g,
                        input bit [7:0] b, input bit rdy);
        ent_t e;
        rst = r_; in_valid = iv; in_sof = isof; in_sol = isol; mode = md;
        v_r = r; v_g = g; v_b = b; vif.out_ready = rdy;
        if (r_) begin
            fq.delete();
            dl0 = '{default: 0};
            dl1 = '{default: 0};
            m_ovf = 0;
            m_lc  = 0;
        end else begin
            if (fq.size() > 0 && rdy)
                void'(fq.pop_front());
            if (dl1.v) begin
                if (fq.size() < DEPTH) fq.push_back(dl1);
                else m_ovf = 1;
            end
            dl1 = dl0;
            e.v   = iv;
            e.w   = {ref_code(md, r), ref_code(md, g), ref_code(md, b)};
            e.sof = isof;
            e.sol = isol;
            dl0 = e;
            if (iv) begin
                if (isof) m_lc = 0;
                else if (isol && m_lc < (1 << LW) - 1) m_lc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(vif.out_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            chk("out_data", 32'(vif.out_data), 32'(fq[0].w));
            chk("out_sof",  32'(vif.out_sof),  32'(fq[0].sof));
            chk("out_sol",  32'(vif.out_sol),  32'(fq[0].sol));
        end else if (r_) begin
            chk("rst_data", 32'(vif.out_data), 32'd0);
            chk("rst_sof",  32'(vif.out_sof),  32'd0);
            chk("rst_sol",  32'(vif.out_sol),  32'd0);
        end
        chk("line_cnt", 32'(line_cnt), m_lc);
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int unsigned n, input bit rdy);
        for (int unsigned i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0, rdy);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0, 0);
        step(1, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0, 0);
    endtask

    int unsigned levels[25] = '{0, 10, 21, 31, 42, 53, 63, 74, 85, 95, 106, 117, 127,
                                138, 149, 159, 170, 181, 191, 202, 213, 223, 234, 245, 255};

    initial begin
        dl0 = '{default: 0};
        dl1 = '{default: 0};
        m_ovf = 0;
        m_lc  = 0;
        do_reset();

        // first sample with sof, two-edge latency into the FIFO
        step(0, 1, 1, 0, 0, 8'd10, 8'd127, 8'd255, 0);
        idle(1, 0);
        chk("lat_not_yet", 32'(vif.out_valid), 32'd0);
        idle(1, 0);
        chk("first_valid", 32'(vif.out_valid), 32'd1);
        chk("first_word",  32'(vif.out_data), 32'h0598);
        chk("first_sof",   32'(vif.out_sof), 32'd1);
        chk("first_lc",    32'(line_cnt), 32'd0);
        idle(3, 1);

        // scaled sweep on all channels, then exact round-trip levels
        for (int unsigned v = 0; v < 256; v++)
            step(0, 1, 0, 0, 0, 8'(v), 8'(v), 8'(v), 1);
        for (int unsigned k = 0; k < 25; k++)
            step(0, 1, 0, 0, 0, 8'(levels[k]), 8'(levels[k]), 8'(levels[k]), 1);
        idle(4, 1);

        // linear mode, then per-pixel mode toggling
        step(0, 1, 0, 0, 1, 8'd8, 8'd255, 8'd7, 0);
        idle(2, 0);
        chk("lin_word", 32'(vif.out_data), 32'h07E0);
        idle(2, 1);
        for (int unsigned i = 0; i < 16; i++)
            step(0, 1, 0, 0, 1'(i), 8'($urandom), 8'($urandom), 8'($urandom), 1);
        idle(4, 1);

        // six samples into a stalled FIFO, then drain
        do_reset();
        for (int unsigned i = 0; i < 6; i++)
            step(0, 1, 0, 0, 0, 8'(i * 40), 8'(i * 20), 8'(255 - i * 30), 0);
        idle(2, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        idle(6, 1);
        chk("drained", 32'(vif.out_valid), 32'd0);

        // full FIFO with continuous input and consumer ready: no drops
        do_reset();
        for (int unsigned i = 0; i < 4; i++)
            step(0, 1, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        idle(2, 0);
        for (int unsigned i = 0; i < 24; i++)
            step(0, 1, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 1);
        chk("stream_no_ovf", 32'(overflow), 32'd0);
        idle(8, 1);

        // line counter: sof, sol pulses, saturation, mid-stream reset
        step(0, 1, 1, 0, 0, 8'd0, 8'd0, 8'd0, 1);
        for (int unsigned i = 0; i < 3; i++)
            step(0, 1, 0, 1, 0, 8'd0, 8'd0, 8'd0, 1);
        chk("lc_three", 32'(line_cnt), 32'd3);
        step(0, 0, 1, 1, 0, 8'd0, 8'd0, 8'd0, 1);
        chk("lc_ignored", 32'(line_cnt), 32'd3);
        step(0, 1, 1, 1, 0, 8'd0, 8'd0, 8'd0, 1);
        chk("lc_sof", 32'(line_cnt), 32'd0);
        for (int unsigned i = 0; i < 1100; i++)
            step(0, 1, 0, 1, 0, 8'd0, 8'd0, 8'd0, 1);
        chk("lc_sat", 32'(line_cnt), 32'd1023);
        for (int unsigned i = 0; i < 6; i++)
            step(0, 1, 0, 0, 0, 8'd200, 8'd100, 8'd50, 0);
        step(1, 1, 0, 0, 0, 8'd200, 8'd100, 8'd50, 0);
        chk("rst_valid", 32'(vif.out_valid), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        idle(4, 1);

        // random traffic
        for (int unsigned i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0));
        idle(8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
